// File: rtl/sfpadd_rr_sched_pkg.sv
// Shared constants, id width helper and tag type
// for the sfpadd round-robin scheduler slice.
package sfpadd_rr_sched_pkg;

  localparam int expWidth    = 4;
  localparam int sigWidth    = 4;
  localparam int formatWidth = 1 + expWidth + sigWidth;
  localparam int IDW_MAX     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  typedef struct packed {
    logic               v;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/sfpadd_rr_sched_if.sv
// Requester, adder and response bundle of the
// shared-adder scheduler.
interface sfpadd_rr_sched_if
  import sfpadd_rr_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 3
);
  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(ADD_LAT + 2);
  localparam int FW  = formatWidth;

  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FW-1:0]   req_a;
  logic [NREQ*FW-1:0]   req_b;
  logic                 add_start;
  logic [FW-1:0]        add_a;
  logic [FW-1:0]        add_b;
  logic [FW-1:0]        add_c;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [FW-1:0]        rsp_c;
  logic [CW-1:0]        inflight;
  logic                 idle;

  modport master (
    input  hold, req_valid, req_a, req_b, add_c,
    output req_ready, add_start, add_a, add_b,
    output rsp_valid, rsp_id, rsp_c, inflight, idle
  );

  modport slave (
    output hold, req_valid, req_a, req_b, add_c,
    input  req_ready, add_start, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_c, inflight, idle
  );

endinterface

// File: rtl/sfpadd_rr_sched_arb.sv
// Combinational round-robin pick: first set req
// bit at or after ptr, wrapping modulo NREQ.
module sfpadd_rr_sched_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] lane;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    lane = '0;
    for (int k = 0; k < NREQ; k++) begin
      lane = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[lane]) begin
        any = 1'b1;
        idx = lane;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sfpadd_rr_sched.sv
// Round-robin issue of requester operand pairs into one
// pipelined sfpadd, with id-tagged result return.
module sfpadd_rr_sched
  import sfpadd_rr_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 3
) (
  input logic               clk,
  input logic               rst,
  sfpadd_rr_sched_if.master bus
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(ADD_LAT + 2);
  localparam int FW  = formatWidth;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic            issue;
  logic            ret;
  logic [FW-1:0]   sel_a;
  logic [FW-1:0]   sel_b;

  logic            add_start_q;
  logic [FW-1:0]   add_a_q;
  logic [FW-1:0]   add_b_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [FW-1:0]   rsp_c_q;
  logic [CW-1:0]   inflight_q;

  // stage 0 rides with add_start; the last stage lines up with add_c
  tag_t tag_q [ADD_LAT+1];

  sfpadd_rr_sched_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign issue = any & ~bus.hold & ~rst;
  assign ret   = tag_q[ADD_LAT].v;
  assign sel_a = bus.req_a[gidx*FW +: FW];
  assign sel_b = bus.req_b[gidx*FW +: FW];

  assign bus.req_ready = issue ? gnt : '0;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.inflight  = inflight_q;
  assign bus.idle      = (inflight_q == '0) & ~|bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      inflight_q  <= '0;
      for (int k = 0; k <= ADD_LAT; k++)
        tag_q[k] <= '0;
    end else begin
      add_start_q <= issue;
      if (issue) begin
        add_a_q <= sel_a;
        add_b_q <= sel_b;
        ptr     <= (gidx == IDW'(NREQ - 1)) ? '0
                                             : gidx + 1'b1;
      end
      tag_q[0].v  <= issue;
      tag_q[0].id <= IDW_MAX'(gidx);
      for (int k = 1; k <= ADD_LAT; k++)
        tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= ret;
      if (ret) begin
        rsp_id_q <= IDW'(tag_q[ADD_LAT].id);
        rsp_c_q  <= bus.add_c;
      end
      case ({issue, ret})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sfpadd_rr_sched.sv
// Bench for sfpadd_rr_sched: XOR stub adder, queue-based
// reference model checked every cycle, directed + random.
module tb_sfpadd_rr_sched;
  import sfpadd_rr_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int L    = 3;
  localparam int FW   = formatWidth;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfpadd_rr_sched_if #(.NREQ(NREQ), .ADD_LAT(L)) bus ();

  sfpadd_rr_sched #(.NREQ(NREQ), .ADD_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [FW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= bus.add_a ^ bus.add_b;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.add_c = pipe[L-1];

  typedef struct {
    int            id;
    logic [FW-1:0] c;
    int            g;
    int            due;
  } op_t;

  op_t           q[$];
  int            mptr;
  logic          exp_start;
  logic [FW-1:0] exp_a, exp_b;
  int            checks, failures, cyc;
  bit            sampled;

  function automatic int pick(int p, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic look();
    int g, n;
    logic [NREQ-1:0] er;
    op_t o;
    @(negedge clk);
    g  = (rst || bus.hold) ? -1 : pick(mptr, bus.req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("add_start", 32'(bus.add_start), 32'(exp_start));
    chk("add_a", 32'(bus.add_a), 32'(exp_a));
    chk("add_b", 32'(bus.add_b), 32'(exp_b));
    n = 0;
    foreach (q[i]) if (q[i].g < cyc && cyc < q[i].due) n++;
    chk("inflight", 32'(bus.inflight), n);
    chk("idle", 32'(bus.idle), 32'(n == 0 && bus.req_valid == 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_id", 32'(bus.rsp_id), q[0].id);
      chk("rsp_c", 32'(bus.rsp_c), 32'(q[0].c));
      void'(q.pop_front());
    end else begin
      chk("rsp_valid", 32'(bus.rsp_valid), 0);
    end
    if (rst) begin
      q.delete();
      mptr = 0; exp_start = 0; exp_a = '0; exp_b = '0;
    end else begin
      exp_start = (g >= 0);
      if (g >= 0) begin
        exp_a = bus.req_a[g*FW +: FW];
        exp_b = bus.req_b[g*FW +: FW];
        o.id = g; o.c = exp_a ^ exp_b; o.g = cyc; o.due = cyc + L + 2;
        q.push_back(o);
        mptr = (g + 1) % NREQ;
      end
    end
    sampled = 1;
  endtask

  task automatic nxt();
    if (!sampled) look();
    @(posedge clk); #1;
    cyc++;
    sampled = 0;
  endtask

  task automatic rand_ops();
    bus.req_a = (NREQ*FW)'({$urandom(), $urandom()});
    bus.req_b = (NREQ*FW)'({$urandom(), $urandom()});
  endtask

  int ids[$];
  int peak, n_start, n_rsp;

  initial begin
    checks = 0; failures = 0; cyc = 0; sampled = 1;
    mptr = 0; exp_start = 0; exp_a = '0; exp_b = '0;
    rst = 1; bus.hold = 0; bus.req_valid = '1;
    rand_ops();
    @(posedge clk); #1;
    cyc = 1; sampled = 0;

    for (int i = 0; i < 3; i++) begin
      look();
      if (i == 2) begin
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_start", 32'(bus.add_start), 0);
        chk("rst_rsp_v", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_c", 32'(bus.rsp_c), 0);
        chk("rst_inflight", 32'(bus.inflight), 0);
        chk("rst_idle", 32'(bus.idle), 0);
      end
      nxt();
    end
    rst = 0; bus.req_valid = '0;
    nxt();

    peak = 0;
    bus.req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      rand_ops();
      look();
      if (k < 8) chk("fair_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
      nxt();
      if (k == 7) bus.req_valid = '0;
    end
    chk("fair_peak", peak, 4);
    chk("fair_nrsp", ids.size(), 8);
    foreach (ids[i]) chk("fair_order", ids[i], i % 4);

    bus.req_valid = 4'b0100;
    bus.req_a[2*FW +: FW] = 9'h0A5;
    bus.req_b[2*FW +: FW] = 9'h00F;
    look();
    chk("single_grant", 32'(bus.req_ready), 32'h4);
    nxt();
    bus.req_valid = '0;
    look();
    chk("single_start", 32'(bus.add_start), 1);
    chk("single_a", 32'(bus.add_a), 32'h0A5);
    nxt();
    for (int k = 0; k < 3; k++) nxt();
    look();
    chk("single_rsp_v", 32'(bus.rsp_valid), 1);
    chk("single_rsp_id", 32'(bus.rsp_id), 2);
    chk("single_rsp_c", 32'(bus.rsp_c), 32'h0AA);
    nxt();

    bus.req_valid = '1;
    rand_ops();
    look();
    chk("hold_g0", 32'(bus.req_ready), 32'h8);
    nxt();
    rand_ops();
    look();
    chk("hold_g1", 32'(bus.req_ready), 32'h1);
    nxt();
    bus.hold = 1;
    n_start = 0; n_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      look();
      chk("hold_ready", 32'(bus.req_ready), 0);
      n_start += int'(bus.add_start);
      n_rsp   += int'(bus.rsp_valid);
      nxt();
    end
    chk("hold_starts", n_start, 1);
    chk("hold_rsps", n_rsp, 2);
    bus.req_valid = '0;
    look();
    chk("hold_idle", 32'(bus.idle), 1);
    nxt();
    bus.hold = 0; bus.req_valid = '1;
    look();
    chk("hold_resume", 32'(bus.req_ready), 32'h2);
    nxt();
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) nxt();

    bus.req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      nxt();
    end
    bus.req_valid = '0; rst = 1;
    look();
    chk("midrst_pre", 32'(bus.inflight), 3);
    nxt();
    rst = 0;
    for (int k = 0; k < L + 2; k++) begin
      look();
      chk("midrst_rsp", 32'(bus.rsp_valid), 0);
      chk("midrst_inflight", 32'(bus.inflight), 0);
      nxt();
    end

    bus.req_valid = 4'b0010;
    nxt();
    bus.req_valid = 4'b1010;
    look();
    chk("skip_g3", 32'(bus.req_ready), 32'h8);
    nxt();
    look();
    chk("skip_g1", 32'(bus.req_ready), 32'h2);
    chk("skip_start0", 32'(bus.add_start), 1);
    nxt();
    bus.req_valid = '0;
    look();
    chk("skip_start1", 32'(bus.add_start), 1);
    nxt();
    for (int k = 0; k < 6; k++) nxt();

    for (int k = 0; k < 400; k++) begin
      bus.req_valid = NREQ'($urandom());
      bus.hold      = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      rand_ops();
      nxt();
    end
    rst = 0; bus.hold = 0; bus.req_valid = '0;
    for (int k = 0; k < 8; k++) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
